// File: rtl/mac_lanes_acc.sv
// Multi-lane signed multiply-accumulate over framed beat sequences.
// Two pipeline stages (lane products, then accumulate), then one rescaled, saturated result per frame.
module mac_lanes_acc #(
    parameter int W     = 5,
    parameter int LANES = 4,
    parameter int FRAC  = 0,
    parameter int ACC_W = 2*W+8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [LANES*W-1:0] x,
    input  logic [LANES*W-1:0] c,
    output logic [W-1:0]       o,
    output logic               out_valid,
    output logic               sat,
    output logic               err
);
    localparam int PS_W = 2*W + $clog2(LANES);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [ACC_W-1:0] O_MAX   = ACC_W'((2**(W-1))-1);
    localparam logic signed [ACC_W-1:0] O_MIN   = ~O_MAX;

    logic signed [2*W-1:0]   prod [LANES];
    logic signed [PS_W-1:0]  psum_next;
    logic signed [PS_W-1:0]  psum_reg;
    logic [0:0]              state_reg, state_next;
    logic                    accept, frame_err;
    logic                    s1_valid_reg, s1_first_reg, s1_last_reg;
    logic                    err_reg;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic signed [ACC_W:0]   sum_wide;
    logic                    acc_clamp;
    logic                    sat_r_reg, sat_r_next;
    logic signed [ACC_W-1:0] shifted;
    logic [W-1:0]            o_next;
    logic                    o_clamp;
    logic [W-1:0]            o_reg;
    logic                    out_valid_reg, sat_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign prod[gi] = (2*W)'($signed(x[gi*W +: W])) * (2*W)'($signed(c[gi*W +: W]));
        end
    endgenerate

    always_comb begin
        psum_next = '0;
        for (int i = 0; i < LANES; i++) begin
            psum_next = psum_next + PS_W'(prod[i]);
        end
    end

    // Frame tracking happens when the beat is accepted; dropped beats never enter the pipe.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        frame_err  = 1'b0;
        if (in_valid) begin
            if (state_reg == IDLE && !in_first) begin
                frame_err = 1'b1;
            end else begin
                accept     = 1'b1;
                frame_err  = (state_reg == ACC) && in_first;
                state_next = in_last ? IDLE : ACC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            psum_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s1_valid_reg <= accept;
            s1_first_reg <= in_first;
            s1_last_reg  <= in_last;
            err_reg      <= frame_err;
            if (accept) begin
                psum_reg <= psum_next;
            end
        end
    end

    // One extra bit of headroom makes accumulator overflow visible as a sign disagreement.
    always_comb begin
        if (s1_first_reg) begin
            sum_wide = (ACC_W+1)'(psum_reg);
        end else begin
            sum_wide = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(psum_reg);
        end
        acc_clamp = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (acc_clamp) begin
            acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum_wide[ACC_W-1:0];
        end
        sat_r_next = (s1_first_reg ? 1'b0 : sat_r_reg) | acc_clamp;

        shifted = acc_next >>> FRAC;
        o_clamp = 1'b1;
        if (shifted > O_MAX) begin
            o_next = O_MAX[W-1:0];
        end else if (shifted < O_MIN) begin
            o_next = O_MIN[W-1:0];
        end else begin
            o_next  = shifted[W-1:0];
            o_clamp = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            sat_r_reg     <= 1'b0;
            o_reg         <= '0;
            out_valid_reg <= 1'b0;
            sat_reg       <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg && s1_last_reg;
            if (s1_valid_reg) begin
                acc_reg   <= acc_next;
                sat_r_reg <= sat_r_next;
                if (s1_last_reg) begin
                    o_reg   <= o_next;
                    sat_reg <= sat_r_next | o_clamp;
                end
            end
        end
    end

    assign o         = o_reg;
    assign out_valid = out_valid_reg;
    assign sat       = sat_reg;
    assign err       = err_reg;
endmodule

// File: tb/tb_mac_lanes_acc.sv
// Scoreboard bench for mac_lanes_acc: one FRAC=0 and one FRAC=2 instance share the same beats.
module tb_mac_lanes_acc;
    localparam int W     = 5;
    localparam int LANES = 4;
    localparam int ACC_W = 2*W+8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_first, in_last;
    logic [LANES*W-1:0] x, c;
    logic signed [W-1:0] o0, o2;
    logic               ov0, ov2, sat0, sat2, err0, err2;

    always #5 clk = ~clk;

    mac_lanes_acc #(.W(W), .LANES(LANES), .FRAC(0), .ACC_W(ACC_W)) u_f0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .x(x), .c(c), .o(o0), .out_valid(ov0), .sat(sat0), .err(err0)
    );
    mac_lanes_acc #(.W(W), .LANES(LANES), .FRAC(2), .ACC_W(ACC_W)) u_f2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .x(x), .c(c), .o(o2), .out_valid(ov2), .sat(sat2), .err(err2)
    );

    typedef struct {
        longint o0;
        bit     s0;
        longint o2;
        bit     s2;
    } res_t;

    res_t   exp_q[$];
    res_t   r;
    int     total = 0;
    int     bad   = 0;
    bit     m_state = 1'b0;
    longint m_acc   = 0;
    bit     m_satr  = 1'b0;
    bit     cur_err = 1'b0;
    bit     exp_err_cycle;

    localparam longint AMAX = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint AMIN = -(longint'(1) << (ACC_W-1));

    task automatic check_val(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [LANES*W-1:0] pk(input int a, input int b, input int cc, input int d);
        return {5'(d), 5'(cc), 5'(b), 5'(a)};
    endfunction

    function automatic void out_calc(input longint a, input int frac, output longint ov, output bit s);
        longint sh;
        sh = a >>> frac;
        s  = 1'b1;
        if (sh > 15) ov = 15;
        else if (sh < -16) ov = -16;
        else begin
            ov = sh;
            s  = 1'b0;
        end
    endfunction

    task automatic beat(input bit v, input bit f, input bit l, input logic [LANES*W-1:0] xv, input logic [LANES*W-1:0] cv);
        longint psum;
        res_t   e;
        @(posedge clk);
        #1;
        in_valid = v; in_first = f; in_last = l; x = xv; c = cv;
        cur_err = 1'b0;
        if (v) begin
            psum = 0;
            for (int i = 0; i < LANES; i++)
                psum += longint'($signed(xv[i*W +: W])) * longint'($signed(cv[i*W +: W]));
            if (!m_state && !f) begin
                cur_err = 1'b1;
            end else begin
                cur_err = m_state && f;
                if (f) begin
                    m_acc  = psum;
                    m_satr = 1'b0;
                end else begin
                    m_acc += psum;
                    if (m_acc > AMAX) begin m_acc = AMAX; m_satr = 1'b1; end
                    else if (m_acc < AMIN) begin m_acc = AMIN; m_satr = 1'b1; end
                end
                m_state = !l;
                if (l) begin
                    out_calc(m_acc, 0, e.o0, e.s0);
                    out_calc(m_acc, 2, e.o2, e.s2);
                    e.s0 |= m_satr;
                    e.s2 |= m_satr;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom), 1'($urandom), 20'($urandom), 20'($urandom));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0; cur_err = 1'b0;
        @(posedge clk);
        exp_q.delete();
        m_state = 1'b0; m_acc = 0; m_satr = 1'b0;
        #1 rst = 1'b0;
    endtask

    always @(posedge clk) exp_err_cycle <= rst ? 1'b0 : cur_err;

    always @(negedge clk) begin
        if (ov0 || ov2) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 1, 0);
            end else begin
                r = exp_q.pop_front();
                $display("result o_f0=%0d sat_f0=%0d o_f2=%0d sat_f2=%0d", o0, sat0, o2, sat2);
                check_val("ov_pair", {ov0, ov2}, 2'b11);
                check_val("o_f0", o0, r.o0);
                check_val("sat_f0", sat0, r.s0);
                check_val("o_f2", o2, r.o2);
                check_val("sat_f2", sat2, r.s2);
            end
        end
        if (err0 || err2 || exp_err_cycle) begin
            check_val("err_f0", err0, exp_err_cycle);
            check_val("err_f2", err2, exp_err_cycle);
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; x = '0; c = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_o", o0, 0);
        check_val("rst_ov", ov0, 0);
        check_val("rst_sat", sat0, 0);
        check_val("rst_err", err0, 0);
        rst = 1'b0;
        idle(2);

        // single-lane 3-beat frame: -12, -18, -6
        beat(1, 1, 0, pk(4, 0, 0, 0), pk(-3, 0, 0, 0));
        beat(1, 0, 0, pk(6, 0, 0, 0), pk(-1, 0, 0, 0));
        beat(1, 0, 1, pk(-4, 0, 0, 0), pk(-3, 0, 0, 0));
        // back-to-back one-beat frames
        beat(1, 1, 1, pk(4, 0, 0, 0), pk(-3, 0, 0, 0));
        beat(1, 1, 1, pk(6, 0, 0, 0), pk(3, 0, 0, 0));
        beat(1, 1, 1, pk(-8, 0, 0, 0), pk(4, 0, 0, 0));
        // four lanes
        beat(1, 1, 0, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
        beat(1, 0, 1, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
        beat(1, 1, 0, pk(1, 2, 3, 4), pk(1, -1, 1, -1));
        beat(1, 0, 1, pk(1, 2, 3, 4), pk(1, -1, 1, -1));
        // rescale cases
        beat(1, 1, 1, pk(8, 0, 0, 0), pk(6, 0, 0, 0));
        beat(1, 1, 1, pk(-1, 0, 0, 0), pk(1, 0, 0, 0));
        // bubbles inside a frame
        beat(1, 1, 0, pk(3, 1, 0, 0), pk(2, 2, 0, 0));
        idle(3);
        beat(1, 0, 1, pk(-5, 0, 0, 0), pk(1, 0, 0, 0));
        // framing violations
        idle(1);
        beat(1, 0, 0, pk(7, 0, 0, 0), pk(7, 0, 0, 0));
        beat(1, 0, 1, pk(7, 0, 0, 0), pk(7, 0, 0, 0));
        idle(1);
        beat(1, 1, 0, pk(5, 0, 0, 0), pk(5, 0, 0, 0));
        beat(1, 1, 0, pk(2, 0, 0, 0), pk(3, 0, 0, 0));
        beat(1, 0, 1, pk(1, 0, 0, 0), pk(1, 0, 0, 0));
        idle(3);
        // accumulator saturation, then back into range: sticky sat must survive
        beat(1, 1, 0, pk(-16, -16, -16, -16), pk(-16, -16, -16, -16));
        for (int i = 0; i < 129; i++) beat(1, 0, 0, pk(-16, -16, -16, -16), pk(-16, -16, -16, -16));
        for (int i = 0; i < 136; i++) beat(1, 0, 0, pk(-16, -16, -16, -16), pk(15, 15, 15, 15));
        beat(1, 0, 0, pk(-16, -16, 0, 0), pk(15, 15, 0, 0));
        beat(1, 0, 1, pk(-16, 0, 0, 0), pk(2, 0, 0, 0));
        idle(3);
        // reset one cycle after a last beat
        beat(1, 1, 1, pk(4, 0, 0, 0), pk(3, 0, 0, 0));
        do_reset();
        idle(3);
        check_val("post_rst_o", o0, 0);
        check_val("post_rst_ov", ov0, 0);
        beat(1, 1, 0, pk(2, 1, 0, 0), pk(3, 1, 0, 0));
        beat(1, 0, 1, pk(1, 0, 0, 0), pk(-2, 0, 0, 0));
        idle(2);
        // random traffic
        for (int i = 0; i < 80; i++) begin
            beat(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) == 0), 20'($urandom), 20'($urandom));
        end
        idle(6);
        check_val("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
